// File: rtl/uart_tx_fifo.sv
// Buffered UART transmitter: a valid/ready FIFO feeding a start/data/parity/stop serialiser.
// sig and busy are registered from the FSM state, so the line trails the state by one clock.

module uart_tx_fifo #(
    parameter int DATA_WIDTH = 8,
    parameter int BAUD_RATE  = 9600,
    parameter int CLK_FREQ   = 12_000_000,
    parameter int FIFO_DEPTH = 16,
    parameter int PARITY     = 0,
    parameter int STOP_BITS  = 1,
    localparam int PULSE_WIDTH = CLK_FREQ / BAUD_RATE,
    localparam int CNT_W       = $clog2(FIFO_DEPTH + 1)
) (
    input  logic                  clk,
    input  logic                  rstn,
    input  logic [DATA_WIDTH-1:0] data,
    input  logic                  valid,
    output logic                  ready,
    output logic                  sig,
    output logic                  busy,
    output logic [CNT_W-1:0]      fifo_count
);

    localparam int AW    = (FIFO_DEPTH > 1) ? $clog2(FIFO_DEPTH) : 1;
    localparam int PW_W  = (PULSE_WIDTH > 1) ? $clog2(PULSE_WIDTH) : 1;
    localparam int BIT_W = 4;

    localparam logic [PW_W-1:0]  BAUD_RELOAD = PW_W'(PULSE_WIDTH - 1);
    localparam logic [BIT_W-1:0] LAST_DATA   = BIT_W'(DATA_WIDTH - 1);
    localparam logic [BIT_W-1:0] LAST_STOP   = BIT_W'(STOP_BITS - 1);
    localparam logic [CNT_W-1:0] FULL_COUNT  = CNT_W'(FIFO_DEPTH);

    if (PULSE_WIDTH < 2) begin : g_bad_pulse
        $error("uart_tx_fifo: CLK_FREQ/BAUD_RATE must be at least 2");
    end
    if (DATA_WIDTH < 5 || DATA_WIDTH > 9) begin : g_bad_width
        $error("uart_tx_fifo: DATA_WIDTH must be 5..9");
    end
    if (FIFO_DEPTH < 2 || (FIFO_DEPTH & (FIFO_DEPTH - 1)) != 0) begin : g_bad_depth
        $error("uart_tx_fifo: FIFO_DEPTH must be a power of two >= 2");
    end
    if (PARITY < 0 || PARITY > 2 || STOP_BITS < 1 || STOP_BITS > 2) begin : g_bad_frame
        $error("uart_tx_fifo: PARITY must be 0..2 and STOP_BITS 1..2");
    end

    typedef enum logic [2:0] {
        ST_IDLE   = 3'd0,
        ST_START  = 3'd1,
        ST_DATA   = 3'd2,
        ST_PARITY = 3'd3,
        ST_STOP   = 3'd4
    } state_t;

    logic [DATA_WIDTH-1:0] r_mem [FIFO_DEPTH];
    logic [AW-1:0]         r_wr_ptr;
    logic [AW-1:0]         r_rd_ptr;
    logic [CNT_W-1:0]      r_count;
    logic                  r_ready;
    state_t                r_state;
    state_t                w_next_state;
    logic [PW_W-1:0]       r_baud;
    logic [BIT_W-1:0]      r_bit;
    logic [DATA_WIDTH-1:0] r_shift;
    logic                  r_par;
    logic                  r_sig;
    logic                  r_busy;

    logic                  w_push;
    logic                  w_pop;
    logic                  w_tick;
    logic                  w_nonempty;
    logic                  w_last_data;
    logic                  w_last_stop;
    logic                  w_sig;
    logic                  w_busy;
    logic [CNT_W-1:0]      w_count_next;

    // Even parity is the XOR of the word; odd parity is its complement.
    function automatic logic parity_bit(input logic [DATA_WIDTH-1:0] word);
        logic p;
        p = ^word;
        if (PARITY == 2) begin
            p = ~p;
        end else begin
            p = p;
        end
        return p;
    endfunction

    assign w_push      = valid && r_ready;
    assign w_nonempty  = (r_count != CNT_W'(0));
    assign w_tick      = (r_baud == PW_W'(0));
    assign w_last_data = (r_bit == LAST_DATA);
    assign w_last_stop = (r_bit == LAST_STOP);

    // Occupancy after this edge; a simultaneous push and pop leave it unchanged.
    always_comb begin
        w_count_next = r_count;
        case ({w_push, w_pop})
            2'b10:   w_count_next = r_count + CNT_W'(1);
            2'b01:   w_count_next = r_count - CNT_W'(1);
            default: w_count_next = r_count;
        endcase
    end

    // FIFO storage write port.
    always_ff @(posedge clk) begin
        if (w_push) begin
            r_mem[r_wr_ptr] <= data;
        end
    end

    // FIFO pointers, occupancy and the registered ready flag.
    always_ff @(posedge clk) begin
        if (!rstn) begin
            r_wr_ptr <= AW'(0);
            r_rd_ptr <= AW'(0);
            r_count  <= CNT_W'(0);
            r_ready  <= 1'b0;
        end else begin
            if (w_push) begin
                r_wr_ptr <= r_wr_ptr + AW'(1);
            end
            if (w_pop) begin
                r_rd_ptr <= r_rd_ptr + AW'(1);
            end
            r_count <= w_count_next;
            r_ready <= (w_count_next != FULL_COUNT);
        end
    end

    // FSM state register.
    always_ff @(posedge clk) begin
        if (!rstn) begin
            r_state <= ST_IDLE;
        end else begin
            r_state <= w_next_state;
        end
    end

    // FSM next-state logic; STOP chains straight into START when a word is waiting.
    always_comb begin
        w_next_state = r_state;
        case (r_state)
            ST_IDLE: begin
                if (w_nonempty) w_next_state = ST_START;
                else            w_next_state = ST_IDLE;
            end
            ST_START: begin
                if (w_tick) w_next_state = ST_DATA;
                else        w_next_state = ST_START;
            end
            ST_DATA: begin
                if (w_tick && w_last_data) begin
                    if (PARITY != 0) w_next_state = ST_PARITY;
                    else             w_next_state = ST_STOP;
                end else begin
                    w_next_state = ST_DATA;
                end
            end
            ST_PARITY: begin
                if (w_tick) w_next_state = ST_STOP;
                else        w_next_state = ST_PARITY;
            end
            ST_STOP: begin
                if (w_tick && w_last_stop) begin
                    if (w_nonempty) w_next_state = ST_START;
                    else            w_next_state = ST_IDLE;
                end else begin
                    w_next_state = ST_STOP;
                end
            end
            default: w_next_state = ST_IDLE;
        endcase
    end

    // FSM outputs: line level, busy and FIFO pop request.
    always_comb begin
        w_sig  = 1'b1;
        w_busy = 1'b0;
        w_pop  = 1'b0;
        case (r_state)
            ST_IDLE: begin
                w_sig  = 1'b1;
                w_busy = 1'b0;
                w_pop  = w_nonempty;
            end
            ST_START: begin
                w_sig  = 1'b0;
                w_busy = 1'b1;
            end
            ST_DATA: begin
                w_sig  = r_shift[0];
                w_busy = 1'b1;
            end
            ST_PARITY: begin
                w_sig  = r_par;
                w_busy = 1'b1;
            end
            ST_STOP: begin
                w_sig  = 1'b1;
                w_busy = 1'b1;
                w_pop  = w_tick && w_last_stop && w_nonempty;
            end
            default: begin
                w_sig  = 1'b1;
                w_busy = 1'b0;
                w_pop  = 1'b0;
            end
        endcase
    end

    // Bit-period timer, bit index and the latched frame word.
    always_ff @(posedge clk) begin
        if (!rstn) begin
            r_baud  <= BAUD_RELOAD;
            r_bit   <= BIT_W'(0);
            r_shift <= DATA_WIDTH'(0);
            r_par   <= 1'b0;
        end else begin
            if (r_state == ST_IDLE || w_tick) begin
                r_baud <= BAUD_RELOAD;
            end else begin
                r_baud <= r_baud - PW_W'(1);
            end
            if (r_state == ST_IDLE || r_state != w_next_state) begin
                r_bit <= BIT_W'(0);
            end else if (w_tick) begin
                r_bit <= r_bit + BIT_W'(1);
            end
            if (w_pop) begin
                r_shift <= r_mem[r_rd_ptr];
                r_par   <= parity_bit(r_mem[r_rd_ptr]);
            end else if (r_state == ST_DATA && w_tick) begin
                r_shift <= r_shift >> 1;
            end
        end
    end

    // Registered line outputs; reset drives the line idle even mid-frame.
    always_ff @(posedge clk) begin
        if (!rstn) begin
            r_sig  <= 1'b1;
            r_busy <= 1'b0;
        end else begin
            r_sig  <= w_sig;
            r_busy <= w_busy;
        end
    end

    assign ready      = r_ready;
    assign sig        = r_sig;
    assign busy       = r_busy;
    assign fifo_count = r_count;

endmodule

// File: tb/tb_uart_tx_fifo.sv
// Bench for uart_tx_fifo: four parity/stop configurations checked every cycle against a
// frame-schedule model, plus table-driven frame vectors and hand-written corner sequences.

module tb_uart_tx_fifo;

    localparam int NDUT  = 4;
    localparam int DW    = 8;
    localparam int PW    = 4;
    localparam int DEPTH = 4;
    localparam int CW    = 3;
    localparam int PAR_CFG  [NDUT] = '{0, 1, 2, 0};
    localparam int STOP_CFG [NDUT] = '{1, 1, 1, 2};

    logic          clk = 1'b0;
    logic          rstn;
    logic [DW-1:0] din    [NDUT];
    logic          vld    [NDUT];
    logic          rdy_a  [NDUT];
    logic          sig_a  [NDUT];
    logic          busy_a [NDUT];
    logic [CW-1:0] cnt_a  [NDUT];

    always #5 clk = ~clk;

    uart_tx_fifo #(.DATA_WIDTH(8), .BAUD_RATE(9600), .CLK_FREQ(38400), .FIFO_DEPTH(4),
                   .PARITY(0), .STOP_BITS(1)) dut0 (
        .clk(clk), .rstn(rstn), .data(din[0]), .valid(vld[0]), .ready(rdy_a[0]),
        .sig(sig_a[0]), .busy(busy_a[0]), .fifo_count(cnt_a[0]));
    uart_tx_fifo #(.DATA_WIDTH(8), .BAUD_RATE(9600), .CLK_FREQ(38400), .FIFO_DEPTH(4),
                   .PARITY(1), .STOP_BITS(1)) dut1 (
        .clk(clk), .rstn(rstn), .data(din[1]), .valid(vld[1]), .ready(rdy_a[1]),
        .sig(sig_a[1]), .busy(busy_a[1]), .fifo_count(cnt_a[1]));
    uart_tx_fifo #(.DATA_WIDTH(8), .BAUD_RATE(9600), .CLK_FREQ(38400), .FIFO_DEPTH(4),
                   .PARITY(2), .STOP_BITS(1)) dut2 (
        .clk(clk), .rstn(rstn), .data(din[2]), .valid(vld[2]), .ready(rdy_a[2]),
        .sig(sig_a[2]), .busy(busy_a[2]), .fifo_count(cnt_a[2]));
    uart_tx_fifo #(.DATA_WIDTH(8), .BAUD_RATE(9600), .CLK_FREQ(38400), .FIFO_DEPTH(4),
                   .PARITY(0), .STOP_BITS(2)) dut3 (
        .clk(clk), .rstn(rstn), .data(din[3]), .valid(vld[3]), .ready(rdy_a[3]),
        .sig(sig_a[3]), .busy(busy_a[3]), .fifo_count(cnt_a[3]));

    // Reference model: each accepted word owns a scheduled frame start time on its line.
    typedef struct {
        int            d;
        longint        start;
        logic [DW-1:0] word;
    } frame_t;

    typedef struct {
        int            d;
        logic [DW-1:0] word;
        int            nbits;
        logic [11:0]   bits;
    } vec_t;

    frame_t fq[$];
    longint last_start [NDUT];
    bit     m_rdy      [NDUT];
    longint cyc = 0;
    int     n_checks = 0;
    int     n_pass   = 0;
    bit     rec_on   = 1'b0;
    logic   trace[$];

    task automatic check(input string name, input logic [31:0] act, input logic [31:0] exp);
        n_checks++;
        if (act !== exp) begin
            $display("FAIL %s at cycle %0d: got %0h, expected %0h", name, cyc, act, exp);
        end else begin
            n_pass++;
        end
    endtask

    function automatic int flen(input int d);
        return (1 + DW + ((PAR_CFG[d] != 0) ? 1 : 0) + STOP_CFG[d]) * PW;
    endfunction

    function automatic logic frame_bit(input int d, input logic [DW-1:0] w, input int k);
        logic [DW-1:0] tmp;
        if (k == 0) return 1'b0;
        if (k <= DW) begin
            tmp = w >> (k - 1);
            return tmp[0];
        end
        if (PAR_CFG[d] != 0 && k == DW + 1) return (PAR_CFG[d] == 1) ? ^w : ~^w;
        return 1'b1;
    endfunction

    function automatic int model_count(input int d);
        int n = 0;
        foreach (fq[i]) if (fq[i].d == d && fq[i].start - 1 > cyc) n++;
        return n;
    endfunction

    function automatic int frames_of(input int d);
        int n = 0;
        foreach (fq[i]) if (fq[i].d == d) n++;
        return n;
    endfunction

    task automatic model_edge();
        frame_t f;
        longint s;
        cyc++;
        if (!rstn) begin
            fq.delete();
            for (int d = 0; d < NDUT; d++) begin
                m_rdy[d]      = 1'b0;
                last_start[d] = -1000;
            end
        end else begin
            for (int d = 0; d < NDUT; d++) begin
                if (vld[d] && m_rdy[d]) begin
                    s = cyc + 2;
                    if (last_start[d] + flen(d) > s) s = last_start[d] + flen(d);
                    f.d = d; f.start = s; f.word = din[d];
                    fq.push_back(f);
                    last_start[d] = s;
                end
            end
            for (int i = fq.size() - 1; i >= 0; i--) begin
                if (fq[i].start + flen(fq[i].d) <= cyc) fq.delete(i);
            end
            for (int d = 0; d < NDUT; d++) m_rdy[d] = (model_count(d) != DEPTH);
        end
    endtask

    task automatic compare_all();
        logic exp_s, exp_b;
        for (int d = 0; d < NDUT; d++) begin
            exp_s = 1'b1;
            exp_b = 1'b0;
            foreach (fq[i]) begin
                if (fq[i].d == d && cyc >= fq[i].start && cyc < fq[i].start + flen(d)) begin
                    exp_s = frame_bit(d, fq[i].word, int'((cyc - fq[i].start) / PW));
                    exp_b = 1'b1;
                end
            end
            check($sformatf("model_d%0d {sig,busy,ready,count}", d),
                  {sig_a[d], busy_a[d], rdy_a[d], cnt_a[d]},
                  {exp_s, exp_b, m_rdy[d], CW'(model_count(d))});
        end
    endtask

    task automatic step();
        @(posedge clk);
        model_edge();
        #1;
        compare_all();
        if (rec_on) trace.push_back(sig_a[0]);
    endtask

    task automatic run_until(input longint t);
        while (cyc < t) step();
    endtask

    task automatic wait_idle(input int d);
        int n = 0;
        while ((frames_of(d) != 0 || !m_rdy[d]) && n < 500) begin
            step();
            n++;
        end
        if (n >= 500) check("wait_idle timeout", 32'd0, 32'd1);
    endtask

    task automatic run_vector(input vec_t v);
        longint t0, rel;
        int nb, k;
        logic [11:0] tmp;
        wait_idle(v.d);
        vld[v.d] = 1'b1;
        din[v.d] = v.word;
        step();
        t0 = cyc;
        vld[v.d] = 1'b0;
        din[v.d] = DW'($urandom);
        nb = 0;
        for (int c = 0; c < v.nbits * PW + 4; c++) begin
            step();
            if (busy_a[v.d]) nb++;
            rel = cyc - t0;
            if (rel == 1) check("vec line idle before start", sig_a[v.d], 1'b1);
            if (rel >= 2 && (rel - 2) % PW == 1) begin
                k = int'((rel - 2) / PW);
                if (k < v.nbits) begin
                    tmp = v.bits >> k;
                    check($sformatf("vec d%0d word %0h bit %0d", v.d, v.word, k),
                          sig_a[v.d], tmp[0]);
                end
            end
        end
        check($sformatf("vec d%0d busy length", v.d), nb, v.nbits * PW);
    endtask

    initial begin
        #5_000_000;
        $display("FAIL watchdog: simulation did not finish");
        $fatal(1, "watchdog");
    end

    initial begin
        vec_t   tbl [5];
        longint t0;
        int     w, n, lows, idx, st, prev, busies;
        bit     acc, seen, found;
        logic [DW-1:0] rx;

        // frames listed LSB-first: start, data, [parity], stop(s)
        tbl[0] = '{d: 0, word: 8'hA5, nbits: 10, bits: {2'b00, 1'b1, 8'hA5, 1'b0}};
        tbl[1] = '{d: 1, word: 8'h07, nbits: 11, bits: {1'b0, 1'b1, 1'b1, 8'h07, 1'b0}};
        tbl[2] = '{d: 2, word: 8'h07, nbits: 11, bits: {1'b0, 1'b1, 1'b0, 8'h07, 1'b0}};
        tbl[3] = '{d: 1, word: 8'h00, nbits: 11, bits: {1'b0, 1'b1, 1'b0, 8'h00, 1'b0}};
        tbl[4] = '{d: 3, word: 8'hFF, nbits: 11, bits: {1'b0, 2'b11, 8'hFF, 1'b0}};

        rstn = 1'b0;
        for (int d = 0; d < NDUT; d++) begin
            vld[d] = 1'b0;
            din[d] = '0;
            m_rdy[d] = 1'b0;
            last_start[d] = -1000;
        end

        // reset held three cycles, then release
        repeat (3) step();
        check("reset sig", sig_a[0], 1'b1);
        check("reset busy", busy_a[0], 1'b0);
        check("reset count", cnt_a[0], 3'd0);
        check("reset ready", rdy_a[0], 1'b0);
        rstn = 1'b1;
        step();
        for (int d = 0; d < NDUT; d++) check($sformatf("release ready d%0d", d), rdy_a[d], 1'b1);

        for (int v = 0; v < 5; v++) run_vector(tbl[v]);

        // two stop bits, second frame queued: start bit must follow with no gap
        wait_idle(3);
        vld[3] = 1'b1; din[3] = 8'hFF;
        step();
        t0 = cyc;
        din[3] = 8'h00;
        step();
        vld[3] = 1'b0;
        lows = 0;
        while (cyc < t0 + 45) begin
            step();
            if (cyc >= t0 + 6 && !sig_a[3]) lows++;
        end
        check("stop2 high run low samples", lows, 0);
        step();
        check("stop2 next start bit", sig_a[3], 1'b0);
        check("stop2 busy continuous", busy_a[3], 1'b1);

        // hold valid with 1..6: fill, back-pressure, then in-order zero-gap frames
        wait_idle(0);
        trace.delete();
        rec_on = 1'b1;
        w = 1; n = 0; seen = 1'b0;
        vld[0] = 1'b1; din[0] = 8'h01;
        while (w <= 6 && n < 400) begin
            acc = m_rdy[0];
            step();
            n++;
            if (acc) begin
                w++;
                din[0] = DW'(w);
            end
            if (!seen && model_count(0) == DEPTH) begin
                seen = 1'b1;
                check("full ready low", rdy_a[0], 1'b0);
                check("full count", cnt_a[0], 3'd4);
            end
        end
        vld[0] = 1'b0;
        check("full reached", seen, 1'b1);
        n = 0;
        while (frames_of(0) != 0 && n < 400) begin
            step();
            n++;
        end
        repeat (5) step();
        rec_on = 1'b0;
        idx = 0; prev = -1;
        for (int f = 0; f < 6; f++) begin
            found = 1'b0;
            st = 0;
            for (int i = idx; i < trace.size(); i++) begin
                if (trace[i] == 1'b0) begin
                    st = i;
                    found = 1'b1;
                    break;
                end
            end
            check($sformatf("burst frame %0d found", f), found, 1'b1);
            if (!found || st + 9 * PW + 1 >= trace.size()) break;
            rx = '0;
            for (int k = 1; k <= DW; k++) rx = {trace[st + k * PW + 1], rx[DW-1:1]};
            check($sformatf("burst frame %0d word", f), rx, f + 1);
            if (prev >= 0) check($sformatf("burst frame %0d spacing", f), st - prev, 40);
            prev = st;
            idx = st + 9 * PW;
        end

        // reset during data bit 3 of the first of three queued frames
        wait_idle(0);
        vld[0] = 1'b1; din[0] = 8'h11;
        step();
        t0 = cyc;
        din[0] = 8'h22;
        step();
        din[0] = 8'h33;
        step();
        vld[0] = 1'b0;
        run_until(t0 + 2 + 17);
        rstn = 1'b0;
        step();
        check("abort sig", sig_a[0], 1'b1);
        check("abort count", cnt_a[0], 3'd0);
        check("abort busy", busy_a[0], 1'b0);
        check("abort ready", rdy_a[0], 1'b0);
        step();
        step();
        rstn = 1'b1;
        step();
        check("abort release ready", rdy_a[0], 1'b1);
        lows = 0; busies = 0;
        repeat (100) begin
            step();
            if (!sig_a[0]) lows++;
            if (busy_a[0]) busies++;
        end
        check("abort no frames after release", lows, 0);
        check("abort no busy after release", busies, 0);

        // randomized traffic on all four lines at varying densities, occasional reset
        for (int blk = 0; blk < 4; blk++) begin
            int dens;
            dens = (blk == 0) ? 10 : (blk == 1) ? 60 : (blk == 2) ? 95 : 30;
            for (int c = 0; c < 600; c++) begin
                for (int d = 0; d < NDUT; d++) begin
                    vld[d] = ($urandom_range(0, 99) < dens);
                    din[d] = DW'($urandom);
                end
                rstn = ($urandom_range(0, 699) != 0);
                step();
            end
        end
        rstn = 1'b1;
        for (int d = 0; d < NDUT; d++) vld[d] = 1'b0;
        repeat (400) step();

        $display("%0d/%0d checks passed", n_pass, n_checks);
        $finish;
    end

endmodule
